// File: rtl/mmu_sram_pkg.sv
// mmu_sram_pkg: shared definitions for the THCO memory responder.
//   - MEM stage operation encodings (memOp)
//   - default NOP instruction encoding
//   - responder FSM state encoding
package mmu_sram_pkg;

    localparam logic [1:0]  MEM_NOP_OP   = 2'b00;
    localparam logic [1:0]  MEM_READ_OP  = 2'b01;
    localparam logic [1:0]  MEM_WRITE_OP = 2'b10;

    localparam logic [15:0] NOP_INST_DEF = 16'h0800;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DRD  = 3'd1,
        S_WR1  = 3'd2,
        S_WR2  = 3'd3,
        S_WR3  = 3'd4,
        S_IF   = 3'd5,
        S_DONE = 3'd6
    } state_e;

endpackage

// File: rtl/mmu_sram.sv
// mmu_sram: memory responder serving one MEM-stage data access followed by
// one IF-stage instruction fetch per pipeline slot over a shared async SRAM.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   memOp_i           data operation (NOP/READ/WRITE; 2'b11 acts as NOP)
//   memAddr_i         data address
//   memData_i         store data
//   data_o            load result (holds last load)
//   pc_i              fetch address
//   inst_o            fetched instruction
//   stall_o           1 = pipeline holds its stage registers
//   ram_addr_o        SRAM address (zero-extended)
//   ram_data_io       SRAM data bus (driven only while writing)
//   ram_en_n_o        SRAM chip enable, active-low
//   ram_oe_n_o        SRAM output enable, active-low
//   ram_we_n_o        SRAM write enable, active-low
module mmu_sram
    import mmu_sram_pkg::*;
#(
    parameter int                RAM_ADDR_W = 18,
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] NOP_INST   = NOP_INST_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            memOp_i,
    input  logic [15:0]           memAddr_i,
    input  logic [DATA_W-1:0]     memData_i,
    output logic [DATA_W-1:0]     data_o,
    input  logic [15:0]           pc_i,
    output logic [DATA_W-1:0]     inst_o,
    output logic                  stall_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    inout  tri   [DATA_W-1:0]     ram_data_io,
    output logic                  ram_en_n_o,
    output logic                  ram_oe_n_o,
    output logic                  ram_we_n_o
);

    state_e              state_q, state_d;
    logic [15:0]         addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [15:0]         pc_q,    pc_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [DATA_W-1:0]   inst_q,  inst_d;

    logic                bus_oe;
    logic [15:0]         addr_sel;

    // State and request/result registers; reset forces all strobes inactive
    // immediately because every strobe is decoded from state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 16'h0000;
            wdata_q <= {DATA_W{1'b0}};
            pc_q    <= 16'h0000;
            data_q  <= {DATA_W{1'b0}};
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            inst_q  <= inst_d;
        end
    end

    // Next-state logic: request sampled only in S_IDLE, results captured
    // from the bus on the edge leaving the corresponding read state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        data_d  = data_q;
        inst_d  = inst_q;
        case (state_q)
            S_IDLE: begin
                addr_d  = memAddr_i;
                wdata_d = memData_i;
                pc_d    = pc_i;
                if (memOp_i == MEM_READ_OP) begin
                    state_d = S_DRD;
                end else if (memOp_i == MEM_WRITE_OP) begin
                    state_d = S_WR1;
                end else begin
                    // NOP and the unused 2'b11 skip straight to the fetch
                    state_d = S_IF;
                end
            end
            S_DRD: begin
                data_d  = ram_data_io;
                state_d = S_IF;
            end
            S_WR1:   state_d = S_WR2;
            S_WR2:   state_d = S_WR3;
            S_WR3:   state_d = S_IF;
            S_IF: begin
                inst_d  = ram_data_io;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // SRAM strobe/address decode from registered state only. WE is framed by
    // S_WR1/S_WR3 so address and data are stable around the write pulse.
    always_comb begin
        ram_en_n_o = 1'b1;
        ram_oe_n_o = 1'b1;
        ram_we_n_o = 1'b1;
        bus_oe     = 1'b0;
        addr_sel   = 16'h0000;
        case (state_q)
            S_DRD: begin
                ram_en_n_o = 1'b0;
                ram_oe_n_o = 1'b0;
                addr_sel   = addr_q;
            end
            S_WR1, S_WR3: begin
                ram_en_n_o = 1'b0;
                bus_oe     = 1'b1;
                addr_sel   = addr_q;
            end
            S_WR2: begin
                ram_en_n_o = 1'b0;
                ram_we_n_o = 1'b0;
                bus_oe     = 1'b1;
                addr_sel   = addr_q;
            end
            S_IF: begin
                ram_en_n_o = 1'b0;
                ram_oe_n_o = 1'b0;
                addr_sel   = pc_q;
            end
            default: begin
                ram_en_n_o = 1'b1;
            end
        endcase
    end

    assign ram_addr_o  = {{(RAM_ADDR_W-16){1'b0}}, addr_sel};
    assign ram_data_io = bus_oe ? wdata_q : {DATA_W{1'bz}};
    assign stall_o     = (state_q != S_DONE);
    assign data_o      = data_q;
    assign inst_o      = inst_q;

endmodule

// File: tb/tb_mmu_sram.sv
module tb_mmu_sram;
    import mmu_sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  memOp_i = 2'b00;
    logic [15:0] memAddr_i = 16'h0000;
    logic [15:0] memData_i = 16'h0000;
    logic [15:0] pc_i = 16'h0000;
    logic [15:0] data_o, inst_o;
    logic        stall_o;
    logic [17:0] ram_addr_o;
    tri   [15:0] ram_data_io;
    logic        ram_en_n_o, ram_oe_n_o, ram_we_n_o;

    mmu_sram dut (
        .clk(clk), .rst(rst),
        .memOp_i(memOp_i), .memAddr_i(memAddr_i), .memData_i(memData_i),
        .data_o(data_o), .pc_i(pc_i), .inst_o(inst_o), .stall_o(stall_o),
        .ram_addr_o(ram_addr_o), .ram_data_io(ram_data_io),
        .ram_en_n_o(ram_en_n_o), .ram_oe_n_o(ram_oe_n_o), .ram_we_n_o(ram_we_n_o)
    );

    always #5 clk = ~clk;

    // SRAM model plus a probe driver used to prove the DUT releases the bus
    logic [15:0] tb_mem  [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic        probe_en = 1'b1;
    wire         sram_rd = !ram_en_n_o && !ram_oe_n_o && ram_we_n_o;
    assign ram_data_io = sram_rd ? tb_mem[ram_addr_o[15:0]] :
                         (probe_en ? 16'h5AA5 : 16'hzzzz);

    always @(negedge clk)
        if (!ram_en_n_o && !ram_we_n_o) tb_mem[ram_addr_o[15:0]] <= ram_data_io;

    typedef struct {
        logic [15:0] data;
        logic [15:0] inst;
        logic [15:0] wd;
        int          len;
        int          we;
        int          wbus;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_data = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: per-slot counters, popped and compared whenever stall drops
    int len_c = 0, we_c = 0, wb_c = 0;
    always @(negedge clk) begin
        if (rst) begin
            len_c = 0; we_c = 0; wb_c = 0;
        end else begin
            exp_t e;
            len_c++;
            if (!ram_we_n_o) we_c++;
            if (!ram_en_n_o && ram_oe_n_o && exp_q.size() > 0 && ram_data_io == exp_q[0].wd)
                wb_c++;
            chk("oe_we_excl", {31'd0, (!ram_oe_n_o && !ram_we_n_o)}, 32'd0);
            chk("addr_hi", {30'd0, ram_addr_o[17:16]}, 32'd0);
            if (!stall_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_o", {16'd0, data_o}, {16'd0, e.data});
                    chk("inst_o", {16'd0, inst_o}, {16'd0, e.inst});
                    chk("slot_len", len_c, e.len);
                    chk("we_cycles", we_c, e.we);
                    chk("wbus_cycles", wb_c, e.wbus);
                end
                len_c = 0; we_c = 0; wb_c = 0;
            end
        end
    end

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall_o) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            bad++;
            $display("FAIL slot_timeout: stall_o stuck at 1 after 20 cycles");
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "timeout");
        end
    endtask

    // Issue one slot from the reference model's view, then scramble inputs
    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] p, input bit first);
        exp_t e;
        memOp_i = op; memAddr_i = a; memData_i = d; pc_i = p;
        if (op == MEM_WRITE_OP) ref_mem[a] = d;
        if (op == MEM_READ_OP)  exp_data = ref_mem[a];
        e.data = exp_data;
        e.inst = ref_mem[p];
        e.wd   = d;
        e.len  = (op == MEM_READ_OP) ? 4 : ((op == MEM_WRITE_OP) ? 6 : 3);
        e.we   = (op == MEM_WRITE_OP) ? 1 : 0;
        e.wbus = (op == MEM_WRITE_OP) ? 3 : 0;
        exp_q.push_back(e);
        @(posedge clk);
        if (first) begin #1; rst = 1'b0; probe_en = 1'b0; end
        @(posedge clk);
        #1;
        memOp_i   = 2'($urandom);
        memAddr_i = 16'($urandom);
        memData_i = 16'($urandom);
        pc_i      = 16'($urandom);
        wait_done();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_stall"}, {31'd0, stall_o}, 32'd1);
        chk({tag, "_inst"}, {16'd0, inst_o}, 32'h0800);
        chk({tag, "_data"}, {16'd0, data_o}, 32'd0);
        chk({tag, "_strobes"}, {29'd0, ram_en_n_o, ram_oe_n_o, ram_we_n_o}, 32'd7);
        chk({tag, "_addr"}, {14'd0, ram_addr_o}, 32'd0);
        chk({tag, "_bus"}, {16'd0, ram_data_io}, 32'h5AA5);
    endtask

    function automatic logic [15:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
    endfunction

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 65536; i++) begin
            v = 16'($urandom);
            tb_mem[i] = v;
            ref_mem[i] = v;
        end
        tb_mem[16'h0010] = 16'h4A01;
        ref_mem[16'h0010] = 16'h4A01;

        repeat (3) @(posedge clk);
        #1 check_reset_state("reset");

        // Directed slots
        issue(MEM_NOP_OP,   16'h0000, 16'h0000, 16'h0010, 1'b1);
        issue(MEM_WRITE_OP, 16'h8000, 16'h1234, 16'h0011, 1'b0);
        issue(MEM_READ_OP,  16'h8000, 16'h0000, 16'h0012, 1'b0);
        issue(2'b11,        16'h8000, 16'hBEEF, 16'h0013, 1'b0);
        issue(MEM_WRITE_OP, 16'hFFFF, 16'hC3C3, 16'hFFFF, 1'b0);
        issue(MEM_READ_OP,  16'hFFFF, 16'h0000, 16'h8000, 1'b0);

        // Randomized slots
        for (int n = 0; n < 80; n++)
            issue(2'($urandom), rnd_addr(), 16'($urandom), rnd_addr(), 1'b0);

        // Reset asserted while the write pulse is active
        memOp_i = MEM_WRITE_OP; memAddr_i = 16'h7777; memData_i = 16'hA55A; pc_i = 16'h0001;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (!ram_we_n_o) begin hit = 1'b1; break; end
            end
            chk("reach_wr2", {31'd0, hit}, 32'd1);
        end
        rst = 1'b1;
        probe_en = 1'b1;
        #1 check_reset_state("midwrite_rst");
        exp_q.delete();
        exp_data = 16'h0000;
        // a write cut by reset may or may not have landed
        ref_mem[16'h7777] = tb_mem[16'h7777];

        issue(MEM_READ_OP, 16'h8000, 16'h0000, 16'hFFFF, 1'b1);
        issue(MEM_NOP_OP,  16'h0000, 16'h0000, 16'h0010, 1'b0);
        for (int n = 0; n < 10; n++)
            issue(2'($urandom), rnd_addr(), 16'($urandom), rnd_addr(), 1'b0);

        repeat (2) @(posedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
